// File: rtl/mmio_arbiter_if.sv
// Signal bundle of the MMIO arbiter: per-master request side plus the shared MMIO bus.
// The slave modport is the arbiter's view; master is the environment (requesters and MMIO target).
interface mmio_arbiter_if #(
  parameter int NUM_MASTERS = 4
);
  logic [NUM_MASTERS-1:0]       m_req;
  logic [NUM_MASTERS-1:0][20:0] m_address;
  logic [NUM_MASTERS-1:0][31:0] m_write_data;
  logic [NUM_MASTERS-1:0]       m_write;
  logic [NUM_MASTERS-1:0]       m_ack;
  logic [31:0]                  m_read_data;

  logic                         mmio_cs;
  logic [20:0]                  mmio_address;
  logic [31:0]                  mmio_write_data;
  logic                         mmio_write;
  logic                         mmio_read;
  logic [31:0]                  mmio_read_data;

  modport slave (
    input  m_req, m_address, m_write_data, m_write, mmio_read_data,
    output m_ack, m_read_data, mmio_cs, mmio_address, mmio_write_data, mmio_write, mmio_read
  );

  modport master (
    output m_req, m_address, m_write_data, m_write, mmio_read_data,
    input  m_ack, m_read_data, mmio_cs, mmio_address, mmio_write_data, mmio_write, mmio_read
  );
endinterface

// File: rtl/mmio_arbiter.sv
// Round-robin arbiter sharing one MMIO bus among NUM_MASTERS requesters.
// Each transaction runs IDLE -> ISSUE -> ACK with every output registered.
module mmio_arbiter #(
  parameter int NUM_MASTERS = 4
) (
  input  logic          clock,
  input  logic          reset,
  mmio_arbiter_if.slave bus,
  output logic          busy
);

  localparam int IDX_W = $clog2(NUM_MASTERS);

  typedef enum logic [1:0] {IDLE, ISSUE, ACK} state_t;

  state_t                 state;
  logic [IDX_W-1:0]       last_grant;
  logic [IDX_W-1:0]       grant_idx;
  logic [IDX_W-1:0]       next_idx;
  logic                   grant_found;
  int                     cand;

  logic                   cs_q;
  logic                   write_q;
  logic                   read_q;
  logic [20:0]            address_q;
  logic [31:0]            write_data_q;
  logic [NUM_MASTERS-1:0] ack_q;
  logic [31:0]            read_data_q;

  // Scan upward from the master after the last grant, wrapping around.
  always_comb begin
    grant_found = 1'b0;
    next_idx    = last_grant;
    cand        = 0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      cand = int'(last_grant) + k;
      if (cand >= NUM_MASTERS) cand = cand - NUM_MASTERS;
      if (!grant_found && bus.m_req[IDX_W'(cand)]) begin
        grant_found = 1'b1;
        next_idx    = IDX_W'(cand);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      last_grant   <= IDX_W'(NUM_MASTERS - 1);
      grant_idx    <= '0;
      busy         <= 1'b0;
      cs_q         <= 1'b0;
      write_q      <= 1'b0;
      read_q       <= 1'b0;
      address_q    <= '0;
      write_data_q <= '0;
      ack_q        <= '0;
      read_data_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            state        <= ISSUE;
            busy         <= 1'b1;
            cs_q         <= 1'b1;
            write_q      <= bus.m_write[next_idx];
            read_q       <= !bus.m_write[next_idx];
            address_q    <= bus.m_address[next_idx];
            write_data_q <= bus.m_write_data[next_idx];
            grant_idx    <= next_idx;
            last_grant   <= next_idx;
          end
        end
        ISSUE: begin
          state        <= ACK;
          cs_q         <= 1'b0;
          write_q      <= 1'b0;
          read_q       <= 1'b0;
          address_q    <= '0;
          write_data_q <= '0;
          read_data_q  <= read_q ? bus.mmio_read_data : 32'h0;
          ack_q        <= NUM_MASTERS'(1) << grant_idx;
        end
        ACK: begin
          // No arbitration here, so a master still holding m_req during its ack is not re-granted.
          state       <= IDLE;
          busy        <= 1'b0;
          ack_q       <= '0;
          read_data_q <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mmio_cs         = cs_q;
  assign bus.mmio_write      = write_q;
  assign bus.mmio_read       = read_q;
  assign bus.mmio_address    = address_q;
  assign bus.mmio_write_data = write_data_q;
  assign bus.m_ack           = ack_q;
  assign bus.m_read_data     = read_data_q;

endmodule

// File: tb/tb_mmio_arbiter.sv
// Bench for mmio_arbiter: directed scenarios then random traffic, all checked against a
// transaction-level model built from grant edge numbers and round-robin arithmetic.
module tb_mmio_arbiter;

  localparam int N = 4;

  logic clock = 1'b0;
  logic reset;
  logic busy;

  mmio_arbiter_if #(.NUM_MASTERS(N)) bus ();

  mmio_arbiter #(.NUM_MASTERS(N)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave),
    .busy  (busy)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: one granted transaction is issued on the cycle after its grant edge, acked the cycle after that.
  int          edge_n     = 0;
  int          last_grant = N - 1;
  int          free_at    = 0;
  int          g_edge     = -10;
  bit          g_valid    = 1'b0;
  int          g_idx      = 0;
  logic [20:0] g_addr;
  logic [31:0] g_wdata;
  logic [31:0] g_rdata;
  bit          g_write;
  logic [N-1:0] drop_next = '0;

  int ack_order[$];
  int ack_edge[$];

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic model_edge();
    edge_n++;
    if (reset !== 1'b1) return;
    if (g_valid && edge_n == g_edge + 1) g_rdata = g_write ? 32'h0 : bus.mmio_read_data;
    if (edge_n >= free_at && bus.m_req != '0) begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (last_grant + k) % N;
        if (bus.m_req[c] && edge_n != g_edge) begin
          g_idx   = c;
          g_addr  = bus.m_address[c];
          g_wdata = bus.m_write_data[c];
          g_write = bus.m_write[c];
          g_edge  = edge_n;
        end
      end
      last_grant = g_idx;
      free_at    = edge_n + 3;
      g_valid    = 1'b1;
    end
  endtask

  task automatic check_output();
    bit issue;
    bit ack;
    issue = g_valid && reset === 1'b1 && edge_n == g_edge;
    ack   = g_valid && reset === 1'b1 && edge_n == g_edge + 1;
    check("mmio_cs", bus.mmio_cs, issue);
    check("mmio_write", bus.mmio_write, issue && g_write);
    check("mmio_read", bus.mmio_read, issue && !g_write);
    check("mmio_address", bus.mmio_address, issue ? g_addr : 21'h0);
    check("mmio_write_data", bus.mmio_write_data, issue ? g_wdata : 32'h0);
    check("m_ack", bus.m_ack, ack ? (64'd1 << g_idx) : 64'd0);
    check("m_read_data", bus.m_read_data, ack ? g_rdata : 32'h0);
    check("busy", busy, issue || ack);
  endtask

  // Masters drop their request right after the edge that ends their ack cycle.
  task automatic cycle_step();
    @(posedge clock);
    model_edge();
    #1;
    check_output();
    bus.m_req = bus.m_req & ~drop_next;
    drop_next = '0;
    if (g_valid && reset === 1'b1 && edge_n == g_edge + 1) drop_next = N'(1) << g_idx;
  endtask

  task automatic assert_reset();
    reset      = 1'b0;
    g_valid    = 1'b0;
    last_grant = N - 1;
    drop_next  = '0;
    #1;
    check_output();
  endtask

  task automatic release_reset();
    reset   = 1'b1;
    free_at = edge_n + 1;
  endtask

  task automatic set_req(input int m, input bit wr, input logic [20:0] a, input logic [31:0] d);
    bus.m_req[m]        = 1'b1;
    bus.m_write[m]      = wr;
    bus.m_address[m]    = a;
    bus.m_write_data[m] = d;
  endtask

  task automatic apply_stimulus();
    for (int m = 0; m < N; m++) begin
      if (!bus.m_req[m] && $urandom_range(0, 3) == 0)
        set_req(m, 1'($urandom), 21'($urandom), $urandom);
    end
    if (g_valid && reset === 1'b1 && edge_n == g_edge && $urandom_range(0, 3) == 0) begin
      bus.m_req[g_idx]        = 1'b0;
      bus.m_address[g_idx]    = 21'($urandom);
      bus.m_write_data[g_idx] = $urandom;
      bus.m_write[g_idx]      = ~bus.m_write[g_idx];
    end
    bus.mmio_read_data = $urandom;
  endtask

  initial begin
    bus.m_req          = '0;
    bus.m_address      = '0;
    bus.m_write_data   = '0;
    bus.m_write        = '0;
    bus.mmio_read_data = '0;

    assert_reset();
    cycle_step();
    cycle_step();
    release_reset();

    // Fairness: all four request together and each drops only on its own ack.
    for (int m = 0; m < N; m++) set_req(m, 1'($urandom), 21'($urandom), $urandom);
    for (int s = 0; s < 20 && ack_order.size() < N; s++) begin
      cycle_step();
      if (bus.m_ack != '0) begin
        for (int b = 0; b < N; b++) if (bus.m_ack[b]) ack_order.push_back(b);
        ack_edge.push_back(edge_n);
      end
    end
    check("fair_ack_count", ack_order.size(), N);
    for (int i = 0; i < ack_order.size(); i++) begin
      check("fair_order", ack_order[i], i);
      if (i > 0) check("fair_spacing", ack_edge[i] - ack_edge[i-1], 3);
    end
    cycle_step();

    // Write from master 2, request held through the ack cycle.
    set_req(2, 1'b1, 21'h00041, 32'hDEADBEEF);
    cycle_step();
    check("wr_cs", bus.mmio_cs, 1'b1);
    check("wr_strobe", bus.mmio_write, 1'b1);
    check("wr_address", bus.mmio_address, 21'h00041);
    check("wr_data", bus.mmio_write_data, 32'hDEADBEEF);
    cycle_step();
    check("wr_ack", bus.m_ack, 4'b0100);
    check("wr_read_data", bus.m_read_data, 32'h0);
    cycle_step();
    cycle_step();
    check("wr_no_regrant", busy, 1'b0);

    // Read from master 0.
    set_req(0, 1'b0, 21'h00020, 32'h0);
    bus.mmio_read_data = 32'h12345678;
    cycle_step();
    check("rd_strobe", bus.mmio_read, 1'b1);
    check("rd_address", bus.mmio_address, 21'h00020);
    cycle_step();
    check("rd_ack", bus.m_ack, 4'b0001);
    check("rd_data", bus.m_read_data, 32'h12345678);
    check("rd_strobe_off", bus.mmio_read, 1'b0);
    cycle_step();

    // Master 3 drops its request and changes its address right after grant.
    set_req(3, 1'b0, 21'h1ABCD, 32'h0);
    bus.mmio_read_data = 32'hCAFE0003;
    cycle_step();
    check("drop_address", bus.mmio_address, 21'h1ABCD);
    bus.m_req[3]     = 1'b0;
    bus.m_address[3] = 21'h00FF0;
    cycle_step();
    check("drop_ack", bus.m_ack, 4'b1000);
    check("drop_data", bus.m_read_data, 32'hCAFE0003);
    cycle_step();

    // Reset during ISSUE discards the transaction.
    set_req(2, 1'b1, 21'h00777, 32'h01234567);
    cycle_step();
    check("rst_issue_cs", bus.mmio_cs, 1'b1);
    assert_reset();
    check("rst_cs_async", bus.mmio_cs, 1'b0);
    check("rst_busy_async", busy, 1'b0);
    bus.m_req = '0;
    set_req(1, 1'b1, 21'h00111, 32'h11111111);
    set_req(3, 1'b1, 21'h00333, 32'h33333333);
    cycle_step();
    check("rst_no_ack", bus.m_ack, 4'b0000);
    cycle_step();
    release_reset();
    cycle_step();
    check("rst_first_addr", bus.mmio_address, 21'h00111);
    cycle_step();
    check("rst_first_ack", bus.m_ack, 4'b0010);
    repeat (4) cycle_step();
    bus.m_req = '0;

    // Idle period, then round-robin must resume after master 3.
    repeat (10) begin
      cycle_step();
      check("idle_busy", busy, 1'b0);
      check("idle_strobes", {bus.mmio_cs, bus.mmio_read, bus.mmio_write}, 3'b000);
    end
    for (int m = 0; m < N; m++) set_req(m, 1'($urandom), 21'($urandom), $urandom);
    cycle_step();
    cycle_step();
    check("idle_resume_ack", bus.m_ack, 4'b0001);
    repeat (10) cycle_step();
    bus.m_req = '0;

    // Random traffic with occasional resets.
    for (int s = 0; s < 500; s++) begin
      apply_stimulus();
      if ($urandom_range(0, 149) == 0) begin
        assert_reset();
        cycle_step();
        release_reset();
      end
      cycle_step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
